// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine.
// Contents: operation encodings, FSM state type, default widths.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 6;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIXUP,
    DONE
  } state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used to take operand magnitudes
// before the iterative datapath and to restore result signs afterwards.
// Ports:
//   val_i  N-bit input value
//   neg_i  negate when high
//   res_o  val_i or -val_i
module muldiv_signfix #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] val_i,
  input  logic         neg_i,
  output logic [N-1:0] res_o
);

  always_comb begin
    res_o = val_i;
    if (neg_i) res_o = -val_i;
  end

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle multiply/divide engine feeding the HI/LO register file.
// MULT/MULTU use a shift/add loop; DIV/DIVU use restoring division.
// Both run one bit per cycle. The result is presented with a one-cycle
// done pulse.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, op, a, b    request, sampled in IDLE (op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU)
//   cancel             pipeline flush, aborts PREP/RUN/FIXUP
//   busy, done         handshake outputs
//   hi_o, lo_o         product high/low, or remainder/quotient
//   div_zero           valid with done, divide by zero (hi_o/lo_o untouched)
// Build option: MULDIV_FAST_MUL_EN computes MULT/MULTU in one cycle in PREP.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero
);

  state_e               state_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     dvsr_q;
  logic                 neg_res_q, neg_rem_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q, done_q, dz_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 is_div, is_signed;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [WIDTH-1:0]     res_hi, res_lo;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  muldiv_signfix #(.N(WIDTH)) u_mag_a (
    .val_i(a_q), .neg_i(is_signed & a_q[WIDTH-1]), .res_o(mag_a));
  muldiv_signfix #(.N(WIDTH)) u_mag_b (
    .val_i(b_q), .neg_i(is_signed & b_q[WIDTH-1]), .res_o(mag_b));

  // Multiply: the low half of acc holds the remaining multiplier bits and
  // is shifted out LSB first while partial products build in the high half.
  // Divide: acc is {remainder, dividend/quotient}, with quotient bits
  // shifted in at the bottom, MSB first.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, dvsr_q};
    if (!is_div)
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else
      acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  muldiv_signfix #(.N(2*WIDTH)) u_prod_fix (
    .val_i(acc_q), .neg_i(neg_res_q), .res_o(prod_fix));
  muldiv_signfix #(.N(WIDTH)) u_quo_fix (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .res_o(quo_fix));
  muldiv_signfix #(.N(WIDTH)) u_rem_fix (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .res_o(rem_fix));

  assign res_hi = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? quo_fix : prod_fix[WIDTH-1:0];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      dvsr_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          dz_q   <= 1'b0;
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (is_div && (b_q == '0)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dz_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            acc_q     <= {{WIDTH{1'b0}}, mag_a};
            dvsr_q    <= mag_b;
            neg_res_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_rem_q <= is_signed & a_q[WIDTH-1];
            cnt_q     <= '0;
            state_q   <= RUN;
`ifdef MULDIV_FAST_MUL_EN
            // Magnitude product is loaded directly; FIXUP only applies the
            // sign and registers it, so RUN is the stage actually skipped.
            if (!is_div) begin
              acc_q   <= fast_prod;
              state_q <= FIXUP;
            end
`endif
          end
        end
        RUN: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIXUP;
          end
        end
        FIXUP: begin
          busy_q <= 1'b0;
          if (cancel) begin
            state_q <= IDLE;
          end else begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          dz_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 35;
`endif
  localparam int DIV_LAT = 35;
  localparam int DZ_LAT  = 2;

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_o, lo_o;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  muldiv_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o),
    .div_zero(div_zero));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: cyc counts rising edges; sampled 1ns after each edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, {hi_o, lo_o}, {e.hi, e.lo});
        check({e.name, "_divzero"}, 64'(div_zero), 64'(e.dz));
        check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
        check({e.name, "_busy_at_done"}, 64'(busy), 64'd0);
      end
    end
  end

  // A done sampled 1ns after edge k is high on edge k+1, so a latency of
  // L edges after the accepting edge shows up at cyc_now + L.
  task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic edz, input int lat);
    exp_t e;
    @(negedge clk);
    e.hi = eh; e.lo = el; e.dz = edz; e.cyc = cyc + lat; e.name = name;
    sb.push_back(e);
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk);
    #2;
    check({name, "_busy_after_start"}, 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz, input int lat);
    issue(name, o, aa, bb, eh, el, edz, lat);
    wait_idle(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    check("reset_flags", 64'({busy, done, div_zero}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op("mult_neg2x3",   OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, MUL_LAT);
    run_op("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT);
    run_op("mult_maxxmin",  OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, MUL_LAT);
    run_op("div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT);
    run_op("div_7_m2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, DIV_LAT);
    run_op("div_m7_m2",     OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, DIV_LAT);
    run_op("divu_7_2",      OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0, DIV_LAT);
    run_op("divu_max_1",    OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0, DIV_LAT);
    run_op("divu_3_5",      OP_DIVU,  32'd3,         32'd5,        32'd3,         32'd0,         1'b0, DIV_LAT);
    run_op("divu_preload",  OP_DIVU,  32'h0000_2211, 32'h100,      32'h11,        32'h22,        1'b0, DIV_LAT);
    run_op("divu_by_zero",  OP_DIVU,  32'd5,         32'd0,        32'h11,        32'h22,        1'b1, DZ_LAT);

    // Overflow divide; a second start mid-operation must not be queued.
    issue("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, DIV_LAT);
    repeat (8) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle("div_overflow");
    repeat (40) @(negedge clk);

    // Cancel mid-divide: busy drops, no done, outputs keep the last result.
    begin
      @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
      @(posedge clk);
      repeat (11) @(posedge clk);
      @(negedge clk);
      cancel = 1'b1;
      @(posedge clk);
      #2;
      check("cancel_busy", 64'(busy), 64'd0);
      @(negedge clk);
      start = 1'b0;
      cancel = 1'b0;
      repeat (40) @(negedge clk);
      check("cancel_hilo", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
    end

    // Reset mid-divide: outputs clear immediately, no done afterwards.
    begin
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
      @(posedge clk);
      repeat (19) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_hilo", {hi_o, lo_o}, 64'd0);
      check("midrst_flags", 64'({busy, done, div_zero}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
    end

    run_op("multu_after_rst", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, MUL_LAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
